sqrt_seq_fixp: RTL and testbench

// - Sequential fixed-point square root: out = sqrt(in * 2^(2*FRAC_W)), i.e. sqrt(in) with FRAC_W fraction bits.
// - Successor to the combinational multiply-based root: one result bit per clock, no multipliers.
// - Adds parametric widths, optional round-to-nearest, remainder and saturation outputs, valid/ready on both sides.
// - Sits between the sensor/physics datapath and the drop-timing logic.

---
 rtl/sqrt_pkg.sv | 25 ++
 rtl/sqrt_step.sv | 27 ++
 rtl/sqrt_seq_fixp.sv | 113 +++++++++++
 tb/tb_sqrt_seq_fixp.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential fixed-point square root:
// FSM encoding, width derivation and rounding-mode constants.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_NEAREST = 1;

  // Low two bits of every restoring trial value {root, 01}.
  localparam logic [1:0] TRIAL_LSBS = 2'b01;

  function automatic int sqrt_out_w(input int in_w, input int frac_w);
    return (in_w + 1) / 2 + frac_w;
  endfunction

  function automatic int sqrt_rad_w(input int in_w, input int frac_w);
    return 2 * sqrt_out_w(in_w, frac_w);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: brings down two radicand bits,
// tries to subtract {root, 01} and appends the resulting root bit.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic [OUT_W-1:0] i_rem,
  input  logic [OUT_W-2:0] i_root,
  input  logic [1:0]       i_rad_bits,
  output logic [OUT_W+1:0] o_rem,
  output logic [OUT_W-1:0] o_root
);

  // Before the last step the partial remainder fits OUT_W bits and the
  // partial root OUT_W-1 bits, so the shifted operands fit OUT_W+2 bits.
  logic [OUT_W+1:0] w_rem_sh;
  logic [OUT_W+1:0] w_trial;
  logic             w_ge;

  assign w_rem_sh = {i_rem, i_rad_bits};
  assign w_trial  = {1'b0, i_root, TRIAL_LSBS};
  assign w_ge     = (w_rem_sh >= w_trial);
  assign o_rem    = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign o_root   = {i_root, w_ge};

endmodule

// File: rtl/sqrt_seq_fixp.sv
// Sequential fixed-point square root, one root bit per clock, with optional
// round-to-nearest, remainder/saturation outputs and valid/ready handshakes.
module sqrt_seq_fixp
  import sqrt_pkg::*;
#(
  parameter  int IN_W   = 8,
  parameter  int FRAC_W = 8,
  parameter  int ROUND  = 0,
  localparam int OUT_W  = sqrt_out_w(IN_W, FRAC_W),
  localparam int RAD_W  = sqrt_rad_w(IN_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_root,
  output logic [OUT_W:0]   out_rem,
  output logic             out_sat
);

  localparam int ITER_W = $clog2(OUT_W);

  sqrt_state_t      r_state;
  logic [RAD_W-1:0] r_x;
  logic [OUT_W-1:0] r_rem;
  logic [OUT_W-2:0] r_root;
  logic [ITER_W-1:0] r_iter;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_root;
  logic [OUT_W:0]   r_out_rem;
  logic             r_out_sat;

  logic [OUT_W+1:0] w_rem_next;
  logic [OUT_W-1:0] w_root_next;
  logic             w_round_up;
  logic             w_root_max;

  sqrt_step #(
    .OUT_W(OUT_W)
  ) u_step (
    .i_rem      (r_rem),
    .i_root     (r_root),
    .i_rad_bits (r_x[RAD_W-1 -: 2]),
    .o_rem      (w_rem_next),
    .o_root     (w_root_next)
  );

  // rem > r is exactly x >= (r + 0.5)^2 for integers, so no tie case exists.
  assign w_round_up = (ROUND == ROUND_NEAREST) && (w_rem_next > {2'b00, w_root_next});
  assign w_root_max = &w_root_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_iter      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_root  <= '0;
      r_out_rem   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= RAD_W'(in_data) << (2 * FRAC_W);
            r_rem      <= '0;
            r_root     <= '0;
            r_iter     <= ITER_W'(OUT_W - 1);
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_x    <= r_x << 2;
          r_rem  <= w_rem_next[OUT_W-1:0];
          r_root <= w_root_next[OUT_W-2:0];
          r_iter <= r_iter - ITER_W'(1);
          if (r_iter == '0) begin
            r_out_rem   <= w_rem_next[OUT_W:0];
            r_out_sat   <= w_round_up && w_root_max;
            r_out_root  <= (w_round_up && !w_root_max) ? (w_root_next + OUT_W'(1)) : w_root_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_root  = r_out_root;
  assign out_rem   = r_out_rem;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_sqrt_seq_fixp.sv
// Scoreboard bench for sqrt_seq_fixp: defaults (truncate and round) share one
// stimulus stream; an integer-root rounding instance is driven separately.
module tb_sqrt_seq_fixp;

  typedef struct {
    int     din;
    longint root;
    longint rem;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'd0;
  logic       out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [11:0] a_out_root;
  logic [12:0] a_out_rem;
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [11:0] b_out_root;
  logic [12:0] b_out_rem;

  logic       c_in_valid  = 1'b0;
  logic [7:0] c_in_data   = 8'd0;
  logic       c_out_ready = 1'b1;
  logic       c_in_ready, c_out_valid, c_out_sat;
  logic [3:0] c_out_root;
  logic [4:0] c_out_rem;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  longint acc_cyc = 0;
  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_seq_fixp #(.IN_W(8), .FRAC_W(8), .ROUND(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_root(a_out_root),
    .out_rem(a_out_rem), .out_sat(a_out_sat)
  );

  sqrt_seq_fixp #(.IN_W(8), .FRAC_W(8), .ROUND(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_root(b_out_root),
    .out_rem(b_out_rem), .out_sat(b_out_sat)
  );

  sqrt_seq_fixp #(.IN_W(8), .FRAC_W(0), .ROUND(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_root(c_out_root),
    .out_rem(c_out_rem), .out_sat(c_out_sat)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy bit-by-bit root using multiplication, independent of the restoring datapath.
  function automatic exp_t ref_sqrt(input int d, input int frac_w, input int out_w, input bit rnd);
    exp_t   e;
    longint x, r, t;
    x = longint'(d) << (2 * frac_w);
    r = 0;
    for (int b = out_w - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    e.din  = d;
    e.root = r;
    e.rem  = x - r * r;
    e.sat  = 1'b0;
    if (rnd && (e.rem > r)) begin
      if (r == (longint'(1) << out_w) - 1) e.sat = 1'b1;
      else e.root = r + 1;
    end
    return e;
  endfunction

  task automatic send(input int d);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    in_data  = 8'(d);
    in_valid = 1'b1;
    while (!a_in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check_eq("send_timeout", guard, 0);
    else begin
      q_a.push_back(ref_sqrt(d, 8, 12, 1'b0));
      q_b.push_back(ref_sqrt(d, 8, 12, 1'b1));
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic c_send(input int d);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    c_in_data  = 8'(d);
    c_in_valid = 1'b1;
    while (!c_in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check_eq("c_send_timeout", guard, 0);
    else q_c.push_back(ref_sqrt(d, 0, 4, 1'b1));
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    check_eq("drain_left", q_a.size() + q_b.size() + q_c.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_out_valid && out_ready) begin
      if (q_a.size() == 0) check_eq("a_unexpected_result", 1, 0);
      else begin
        e = q_a.pop_front();
        check_eq("a_root", a_out_root, e.root);
        check_eq("a_rem", a_out_rem, e.rem);
        check_eq("a_sat", a_out_sat, e.sat);
        $display("a in=%0d root=%0d rem=%0d sat=%0d", e.din, a_out_root, a_out_rem, a_out_sat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_out_valid && out_ready) begin
      if (q_b.size() == 0) check_eq("b_unexpected_result", 1, 0);
      else begin
        e = q_b.pop_front();
        check_eq("b_root", b_out_root, e.root);
        check_eq("b_rem", b_out_rem, e.rem);
        check_eq("b_sat", b_out_sat, e.sat);
        $display("b in=%0d root=%0d rem=%0d sat=%0d", e.din, b_out_root, b_out_rem, b_out_sat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && c_out_valid && c_out_ready) begin
      if (q_c.size() == 0) check_eq("c_unexpected_result", 1, 0);
      else begin
        e = q_c.pop_front();
        check_eq("c_root", c_out_root, e.root);
        check_eq("c_rem", c_out_rem, e.rem);
        check_eq("c_sat", c_out_sat, e.sat);
        $display("c in=%0d root=%0d rem=%0d sat=%0d", e.din, c_out_root, c_out_rem, c_out_sat);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: finished=0 expected 1");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int     perm[256];
    int     j, tmp, k, cnt;
    longint prev;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", a_in_ready, 1);
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_out_root", a_out_root, 0);
    check_eq("rst_out_rem", a_out_rem, 0);
    check_eq("rst_out_sat", a_out_sat, 0);
    check_eq("rst_c_in_ready", c_in_ready, 1);
    check_eq("rst_c_out_valid", c_out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First result latency: valid must appear after the 12th edge past accept.
    send(4);
    k = 0;
    @(negedge clk);
    while (!a_out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("latency", k, 12);
    drain();

    send(2);
    drain();
    send(255);
    drain();
    send(0);
    drain();

    // Consumer stall: outputs held, no accept, extra in_valid ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2);
    k = 0;
    while (!a_out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("hold_wait_timeout", k < 40, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'd77;
      @(negedge clk);
      check_eq("hold_valid", a_out_valid, 1);
      check_eq("hold_in_ready", a_in_ready, 0);
      if (q_a.size() > 0) begin
        check_eq("hold_root", a_out_root, q_a[0].root);
        check_eq("hold_rem", a_out_rem, q_a[0].rem);
      end
      if (q_b.size() > 0) check_eq("hold_b_root", b_out_root, q_b[0].root);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check_eq("hold_after_valid", a_out_valid, 0);
    check_eq("hold_after_in_ready", a_in_ready, 1);

    // Reset in the middle of a calculation discards the result.
    send(255);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_out_valid || b_out_valid) cnt++;
    end
    check_eq("rst_mid_no_valid", cnt, 0);
    check_eq("rst_mid_in_ready", a_in_ready, 1);
    send(0);
    drain();

    // Full sweep in shuffled order, back to back, with throughput check.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      prev = acc_cyc;
      send(perm[i]);
      if (i > 0) check_eq("period", acc_cyc - prev, 14);
    end
    drain();

    // Integer root with rounding, including the saturating corner at 255.
    c_send(255);
    drain();
    for (int i = 0; i < 256; i++) c_send(i);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
